lsu_ctrl: RTL and testbench
===========================

Name: lsu_ctrl

Overview:
- Memory-stage load/store controller sitting directly upstream of the data cache.
- Accepts one load/store/pass-through op per handshake from the execute stage.
- Drives the cache request interface and holds it until the cache signals completion.
- Size/sign-extends load data and presents the result to writeback through a valid/ready handshake.

Parameters:
CACHE_BASE, 32'h8000_0000, lowest cacheable address (inclusive)
CACHE_LIMIT, 32'h8800_0000, cacheable upper bound (exclusive); loads/stores outside [BASE,LIMIT) fault

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
in_valid  in  1  op valid from execute
in_ready  out  1  controller can accept op
in_load  in  1  op is load
in_store  in  1  op is store
in_funct3  in  3  size: 000 b, 001 h, 010 w, 011 d, 100 bu, 101 hu, 110 wu
in_addr  in  32  effective address
in_wdata  in  64  store data, or ALU result for non-memory ops
in_rd  in  5  destination register, passed through
out_valid  out  1  result valid to writeback
out_ready  in  1  writeback accepts result
out_rd  out  5  latched in_rd
out_data  out  64  load result / pass-through value
out_fault  out  1  access fault for this result
dc_use_cache  out  1  cache enable
dc_r_ren  out  1  load request
dc_r_wen  out  1  store request
dc_raddr  out  32  load address
dc_waddr  out  32  store address
dc_wdata  out  64  store data, low-aligned, upper bytes zero
dc_wmask  out  8  01/03/0F/FF by size, low-aligned
dc_inst_update  out  1  request strobe; held for the whole access
dc_rdata_align  in  64  cache read data, already shifted by addr[2:0]
dc_cache_finish  in  1  one-cycle completion pulse

Behaviour:
- Interface: reset rst, synchronous, active-high; clock clk.
- Reset values: all outputs 0, except in_ready=1. State goes to IDLE. A reset mid-access drops all dc_* on the next edge; the cache shares rst.
- States: IDLE, ACCESS, RESP.
- Accept: in_ready=1 only in IDLE. On in_valid&in_ready, latch addr, funct3, wdata, rd, and op type.
- IDLE -> RESP (out_fault=0, out_data=in_wdata) when neither load nor store is set.
- IDLE -> RESP (out_fault=1, out_data=0, no cache access) when:
  - load and store are both set, or
  - the address is outside [CACHE_BASE,CACHE_LIMIT), or
  - it is a store with funct3[2]=1, or
  - it is a load with funct3=111.
- IDLE -> ACCESS otherwise.
- ACCESS: dc_inst_update=1 and dc_use_cache=1. Exactly one of dc_r_ren/dc_r_wen is set. dc_raddr=dc_waddr=latched addr. All dc_* held stable until dc_cache_finish.
- On the dc_cache_finish cycle:
  - Capture dc_rdata_align, extended per funct3 (lb/lh/lw sign-extend bits 7/15/31; bu/hu/wu zero-extend; d unchanged).
  - Stores give out_data=0.
  - Go to RESP.
  - The next cycle, dc_inst_update, dc_r_ren and dc_r_wen are 0, so the cache returns to idle without restarting.
- RESP: out_valid=1, data/rd/fault stable until out_ready, then IDLE. in_ready stays 0 during RESP even when out_ready=1 (no same-cycle reuse).
- Latency:
  - Non-memory op: out_valid one cycle after accept.
  - Memory op: out_valid the cycle after the dc_cache_finish pulse. On a cache hit that is 4 cycles after accept.
- dc_cache_finish outside ACCESS is ignored.

Optional Feature:
- Macro LSU_MISALIGN_TRAP_EN.
- Defined: a load/store whose addr is not a multiple of its size (h:2, w:4, d:8) goes IDLE -> RESP with out_fault=1, out_data=0, and no cache request.
- Undefined: misaligned accesses are issued unchanged. The result is defined only when the access stays within one 8-byte word.

Test Plan:
- Non-mem op, in_wdata=64'h1234, rd=5 -> out_valid 1 cycle later, out_data=64'h1234, rd=5, fault=0, no dc_inst_update.
- lb at 0x8000_0003, cache model returns rdata_align=64'h..._80 -> dc_r_ren/inst_update held until finish, dropped the cycle after; out_data=64'hFFFF_FFFF_FFFF_FF80; lbu gives 64'h80.
- sh at 0x8000_0010, in_wdata=64'hAAAA_BBBB_CCCC_DDDD -> dc_wmask=8'h03, dc_wdata=64'hDDDD, dc_r_wen=1, out_data=0 after finish.
- ld at 0x1000_0000 -> out_fault=1 next cycle, dc_inst_update never asserts.
- Cache finish delayed 20 cycles with out_ready=0 for 3 cycles after -> request stable for all 20 cycles, out_valid held 3 cycles, in_ready=0 throughout, then in_ready=1.
- rst asserted during ACCESS -> all dc_* and out_valid 0 next edge, in_ready=1. With LSU_MISALIGN_TRAP_EN, lw at 0x8000_0002 -> out_fault=1 and no request.

Source files
------------

// File: rtl/lsu_ctrl_if.sv
// Handshake and cache-request bundle between execute, lsu_ctrl, writeback and the data cache.
// slave: the controller's view; master: the surrounding pipeline and cache.
interface lsu_ctrl_if;
  logic        in_valid;
  logic        in_ready;
  logic        in_load;
  logic        in_store;
  logic [2:0]  in_funct3;
  logic [31:0] in_addr;
  logic [63:0] in_wdata;
  logic [4:0]  in_rd;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  out_rd;
  logic [63:0] out_data;
  logic        out_fault;
  logic        dc_use_cache;
  logic        dc_r_ren;
  logic        dc_r_wen;
  logic [31:0] dc_raddr;
  logic [31:0] dc_waddr;
  logic [63:0] dc_wdata;
  logic [7:0]  dc_wmask;
  logic        dc_inst_update;
  logic [63:0] dc_rdata_align;
  logic        dc_cache_finish;

  modport slave (
    input  in_valid, in_load, in_store, in_funct3, in_addr, in_wdata, in_rd,
    input  out_ready, dc_rdata_align, dc_cache_finish,
    output in_ready, out_valid, out_rd, out_data, out_fault,
    output dc_use_cache, dc_r_ren, dc_r_wen, dc_raddr, dc_waddr, dc_wdata, dc_wmask,
    output dc_inst_update
  );

  modport master (
    output in_valid, in_load, in_store, in_funct3, in_addr, in_wdata, in_rd,
    output out_ready, dc_rdata_align, dc_cache_finish,
    input  in_ready, out_valid, out_rd, out_data, out_fault,
    input  dc_use_cache, dc_r_ren, dc_r_wen, dc_raddr, dc_waddr, dc_wdata, dc_wmask,
    input  dc_inst_update
  );
endinterface

// File: rtl/lsu_ctrl.sv
// Memory-stage load/store controller in front of the data cache (IDLE/ACCESS/RESP).
// Optional misaligned-access trap enabled by defining LSU_MISALIGN_TRAP_EN.
module lsu_ctrl #(
  parameter logic [31:0] CACHE_BASE  = 32'h8000_0000,
  parameter logic [31:0] CACHE_LIMIT = 32'h8800_0000
) (
  input  logic      clk,
  input  logic      rst,
  lsu_ctrl_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t      r_state, w_next;
  logic [31:0] r_addr;
  logic [2:0]  r_funct3;
  logic [63:0] r_wdata;
  logic [4:0]  r_rd;
  logic        r_load, r_store;
  logic [63:0] r_out_data;
  logic        r_out_fault;

  logic        w_accept, w_mem, w_in_range, w_misalign, w_fault, w_access;
  logic [63:0] w_load_ext, w_wdata_al;
  logic [7:0]  w_mask;

  assign w_accept   = bus.in_valid && (r_state == IDLE);
  assign w_mem      = bus.in_load || bus.in_store;
  assign w_in_range = (bus.in_addr >= CACHE_BASE) && (bus.in_addr < CACHE_LIMIT);

`ifdef LSU_MISALIGN_TRAP_EN
  always_comb begin
    w_misalign = 1'b0;
    case (bus.in_funct3[1:0])
      2'b01:   w_misalign = bus.in_addr[0];
      2'b10:   w_misalign = |bus.in_addr[1:0];
      2'b11:   w_misalign = |bus.in_addr[2:0];
      default: w_misalign = 1'b0;
    endcase
  end
`else
  assign w_misalign = 1'b0;
`endif

  // Any fault short-circuits to RESP so the cache never sees the request.
  assign w_fault = (bus.in_load && bus.in_store)
                || (w_mem && !w_in_range)
                || (bus.in_store && bus.in_funct3[2])
                || (bus.in_load && (bus.in_funct3 == 3'b111))
                || (w_mem && w_misalign);

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (bus.in_valid) w_next = (!w_mem || w_fault) ? RESP : ACCESS;
      ACCESS:  if (bus.dc_cache_finish) w_next = RESP;
      RESP:    if (bus.out_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    w_load_ext = '0;
    case (r_funct3)
      3'b000:  w_load_ext = {{56{bus.dc_rdata_align[7]}},  bus.dc_rdata_align[7:0]};
      3'b001:  w_load_ext = {{48{bus.dc_rdata_align[15]}}, bus.dc_rdata_align[15:0]};
      3'b010:  w_load_ext = {{32{bus.dc_rdata_align[31]}}, bus.dc_rdata_align[31:0]};
      3'b011:  w_load_ext = bus.dc_rdata_align;
      3'b100:  w_load_ext = {56'd0, bus.dc_rdata_align[7:0]};
      3'b101:  w_load_ext = {48'd0, bus.dc_rdata_align[15:0]};
      3'b110:  w_load_ext = {32'd0, bus.dc_rdata_align[31:0]};
      default: w_load_ext = '0;
    endcase
  end

  always_comb begin
    w_mask     = 8'hFF;
    w_wdata_al = '0;
    case (r_funct3[1:0])
      2'b00:   w_mask = 8'h01;
      2'b01:   w_mask = 8'h03;
      2'b10:   w_mask = 8'h0F;
      default: w_mask = 8'hFF;
    endcase
    for (int i = 0; i < 8; i++)
      w_wdata_al[8*i +: 8] = w_mask[i] ? r_wdata[8*i +: 8] : 8'h00;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_addr      <= '0;
      r_funct3    <= '0;
      r_wdata     <= '0;
      r_rd        <= '0;
      r_load      <= 1'b0;
      r_store     <= 1'b0;
      r_out_data  <= '0;
      r_out_fault <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_addr      <= bus.in_addr;
        r_funct3    <= bus.in_funct3;
        r_wdata     <= bus.in_wdata;
        r_rd        <= bus.in_rd;
        r_load      <= bus.in_load;
        r_store     <= bus.in_store;
        r_out_fault <= w_fault;
        r_out_data  <= w_mem ? 64'd0 : bus.in_wdata;
      end
      if ((r_state == ACCESS) && bus.dc_cache_finish)
        r_out_data <= r_store ? 64'd0 : w_load_ext;
    end
  end

  // Request outputs decode straight from state so they drop the edge we leave ACCESS.
  assign w_access           = (r_state == ACCESS);
  assign bus.in_ready       = (r_state == IDLE);
  assign bus.out_valid      = (r_state == RESP);
  assign bus.out_rd         = r_rd;
  assign bus.out_data       = r_out_data;
  assign bus.out_fault      = r_out_fault;
  assign bus.dc_use_cache   = w_access;
  assign bus.dc_inst_update = w_access;
  assign bus.dc_r_ren       = w_access && r_load;
  assign bus.dc_r_wen       = w_access && r_store;
  assign bus.dc_raddr       = w_access ? r_addr : 32'd0;
  assign bus.dc_waddr       = w_access ? r_addr : 32'd0;
  assign bus.dc_wdata       = (w_access && r_store) ? w_wdata_al : 64'd0;
  assign bus.dc_wmask       = (w_access && r_store) ? w_mask : 8'h00;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Self-checking bench for lsu_ctrl: vector table, hand-written corner sequences, random ops vs model.
module tb_lsu_ctrl;
  localparam logic [31:0] BASE  = 32'h8000_0000;
  localparam logic [31:0] LIMIT = 32'h8800_0000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  lsu_ctrl_if bus();
  lsu_ctrl #(.CACHE_BASE(BASE), .CACHE_LIMIT(LIMIT)) dut (.clk(clk), .rst(rst), .bus(bus));

  int checks = 0;
  int errors = 0;

  int          g_nacc, g_lat, g_unstable, g_held, g_ready_bad;
  logic        g_timeout, g_drop_bad, g_still_valid, g_after_ok, g_fault, g_ren, g_wen;
  logic [63:0] g_data, g_wdata;
  logic [4:0]  g_rd;
  logic [31:0] g_raddr, g_waddr;
  logic [7:0]  g_wmask;

  typedef struct {
    logic        ld;
    logic        st;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [63:0] wd;
    logic [4:0]  rd;
    logic [63:0] rdat;
    int          dly;
    logic        e_fault;
    logic [63:0] e_data;
    logic        e_acc;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic add(input logic ld, input logic st, input logic [2:0] f3, input logic [31:0] a,
                     input logic [63:0] wd, input logic [4:0] rd, input logic [63:0] rdat,
                     input int dly, input logic ef, input logic [63:0] ed, input logic ea);
    vec_t v;
    v.ld = ld; v.st = st; v.f3 = f3; v.addr = a; v.wd = wd; v.rd = rd; v.rdat = rdat;
    v.dly = dly; v.e_fault = ef; v.e_data = ed; v.e_acc = ea;
    vecs.push_back(v);
  endtask

  // Specification-level reference: range/op/size rules, then mask-and-extend with arithmetic.
  function automatic void model(input logic ld, input logic st, input logic [2:0] f3,
                                input logic [31:0] a, input logic [63:0] wd, input logic [63:0] rdat,
                                output logic m_fault, output logic [63:0] m_data, output logic m_acc);
    int nbytes;
    logic [63:0] keep;
    nbytes = 1 << f3[1:0];
    keep = (nbytes == 8) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (8 * nbytes)) - 64'd1);
    if (!ld && !st) begin
      m_fault = 1'b0; m_data = wd; m_acc = 1'b0;
      return;
    end
    m_fault = (ld && st) || !((a >= BASE) && (a < LIMIT)) || (st && f3 >= 3'd4) || (ld && f3 == 3'd7);
`ifdef LSU_MISALIGN_TRAP_EN
    if ((a % nbytes) != 0) m_fault = 1'b1;
`endif
    m_acc = !m_fault;
    if (m_fault || st) m_data = 64'd0;
    else begin
      m_data = rdat & keep;
      if (f3 < 3'd4 && nbytes < 8 && m_data[8 * nbytes - 1]) m_data = m_data | ~keep;
    end
  endfunction

  task automatic do_op(input logic ld, input logic st, input logic [2:0] f3, input logic [31:0] a,
                       input logic [63:0] wd, input logic [4:0] rd, input logic [63:0] rdat,
                       input int dly, input int stall);
    int cyc;
    logic [138:0] snap, cur;
    logic [69:0]  osnap;
    g_nacc = 0; g_lat = 1; g_unstable = 0; g_held = 0; g_ready_bad = 0;
    g_timeout = 1'b0; g_drop_bad = 1'b0; g_still_valid = 1'b0; g_after_ok = 1'b0;
    g_ren = 1'b0; g_wen = 1'b0; g_raddr = '0; g_waddr = '0; g_wdata = '0; g_wmask = '0;
    snap = '0;
    @(negedge clk);
    bus.in_valid = 1'b1; bus.in_load = ld; bus.in_store = st; bus.in_funct3 = f3;
    bus.in_addr = a; bus.in_wdata = wd; bus.in_rd = rd; bus.out_ready = 1'b0;
    @(negedge clk);
    bus.in_valid = 1'b0; bus.in_load = 1'b0; bus.in_store = 1'b0; bus.in_wdata = '0;
    cyc = 0;
    while (!bus.out_valid && cyc < 100) begin
      if (bus.in_ready) g_ready_bad++;
      if (bus.dc_inst_update) begin
        cur = {bus.dc_use_cache, bus.dc_r_ren, bus.dc_r_wen, bus.dc_raddr, bus.dc_waddr,
               bus.dc_wdata, bus.dc_wmask};
        if (g_nacc == 0) begin
          snap = cur;
          g_ren = bus.dc_r_ren; g_wen = bus.dc_r_wen; g_raddr = bus.dc_raddr;
          g_waddr = bus.dc_waddr; g_wdata = bus.dc_wdata; g_wmask = bus.dc_wmask;
        end else if (cur !== snap) g_unstable++;
        g_nacc++;
        if (g_nacc > dly) begin
          bus.dc_rdata_align = rdat;
          bus.dc_cache_finish = 1'b1;
        end
      end
      @(negedge clk);
      bus.dc_cache_finish = 1'b0;
      bus.dc_rdata_align = {$urandom, $urandom};
      cyc++;
      g_lat++;
    end
    if (!bus.out_valid) begin
      g_timeout = 1'b1;
      bus.out_ready = 1'b1;
      @(negedge clk);
      bus.out_ready = 1'b0;
      return;
    end
    if (bus.dc_inst_update || bus.dc_r_ren || bus.dc_r_wen) g_drop_bad = 1'b1;
    osnap = {bus.out_fault, bus.out_rd, bus.out_data};
    for (int s = 0; s < stall; s++) begin
      if (bus.out_valid && !bus.in_ready && ({bus.out_fault, bus.out_rd, bus.out_data} === osnap))
        g_held++;
      @(negedge clk);
    end
    g_fault = bus.out_fault; g_data = bus.out_data; g_rd = bus.out_rd;
    g_still_valid = bus.out_valid && !bus.in_ready;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    g_after_ok = bus.in_ready && !bus.out_valid;
  endtask

  task automatic check_op(input string nm, input logic ld, input logic st, input logic [31:0] a,
                          input logic ef, input logic [63:0] ed, input logic [4:0] erd,
                          input logic ea, input int dly, input int stall);
    chk({nm, "_timeout"}, 64'(g_timeout), 64'd0);
    if (g_timeout) return;
    chk({nm, "_fault"}, 64'(g_fault), 64'(ef));
    chk({nm, "_data"}, g_data, ed);
    chk({nm, "_rd"}, 64'(g_rd), 64'(erd));
    chk({nm, "_naccess"}, 64'(g_nacc), ea ? 64'(dly + 1) : 64'd0);
    chk({nm, "_latency"}, 64'(g_lat), ea ? 64'(dly + 2) : 64'd1);
    chk({nm, "_inready_busy"}, 64'(g_ready_bad), 64'd0);
    chk({nm, "_held"}, 64'(g_held), 64'(stall));
    chk({nm, "_valid_at_ready"}, 64'(g_still_valid), 64'd1);
    chk({nm, "_idle_after"}, 64'(g_after_ok), 64'd1);
    if (ea) begin
      chk({nm, "_ren"}, 64'(g_ren), 64'(ld));
      chk({nm, "_wen"}, 64'(g_wen), 64'(st));
      chk({nm, "_raddr"}, 64'(g_raddr), 64'(a));
      chk({nm, "_waddr"}, 64'(g_waddr), 64'(a));
      chk({nm, "_stable"}, 64'(g_unstable), 64'd0);
      chk({nm, "_drop"}, 64'(g_drop_bad), 64'd0);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        m_fault, m_acc;
    logic [63:0] m_data;
    int          cyc;

    bus.in_valid = 1'b0; bus.in_load = 1'b0; bus.in_store = 1'b0; bus.in_funct3 = '0;
    bus.in_addr = '0; bus.in_wdata = '0; bus.in_rd = '0; bus.out_ready = 1'b0;
    bus.dc_rdata_align = '0; bus.dc_cache_finish = 1'b0;

    //  ld st f3     addr           wdata                  rd  rdata                  dly fault data                   acc
    add(0, 0, 3'd0, 32'h0,         64'h1234,               5,  64'h0,                  0, 0, 64'h1234,               0);
    add(1, 0, 3'd0, 32'h8000_0003, 64'h0,                  1,  64'h1111_2222_3333_4480, 2, 0, 64'hFFFF_FFFF_FFFF_FF80, 1);
    add(1, 0, 3'd4, 32'h8000_0003, 64'h0,                  2,  64'h1111_2222_3333_4480, 2, 0, 64'h80,                 1);
    add(0, 1, 3'd1, 32'h8000_0010, 64'hAAAA_BBBB_CCCC_DDDD, 3, 64'h0,                  2, 0, 64'h0,                  1);
    add(1, 0, 3'd3, 32'h1000_0000, 64'h0,                  4,  64'h0,                  0, 1, 64'h0,                  0);
    add(1, 0, 3'd1, 32'h8000_0000, 64'h0,                  6,  64'h0000_0000_0000_8001, 1, 0, 64'hFFFF_FFFF_FFFF_8001, 1);
    add(1, 0, 3'd5, 32'h8000_0000, 64'h0,                  7,  64'h0000_0000_0000_8001, 0, 0, 64'h8001,               1);
    add(1, 0, 3'd2, 32'h8000_0004, 64'h0,                  8,  64'hDEAD_BEEF_8765_4321, 2, 0, 64'hFFFF_FFFF_8765_4321, 1);
    add(1, 0, 3'd6, 32'h8000_0004, 64'h0,                  9,  64'hDEAD_BEEF_8765_4321, 3, 0, 64'h8765_4321,          1);
    add(1, 0, 3'd3, 32'h8000_0008, 64'h0,                  10, 64'hDEAD_BEEF_8765_4321, 1, 0, 64'hDEAD_BEEF_8765_4321, 1);
    add(1, 1, 3'd3, 32'h8000_0008, 64'h55,                 11, 64'h0,                  0, 1, 64'h0,                  0);
    add(0, 1, 3'd4, 32'h8000_0008, 64'h55,                 12, 64'h0,                  0, 1, 64'h0,                  0);
    add(1, 0, 3'd7, 32'h8000_0008, 64'h0,                  13, 64'h0,                  0, 1, 64'h0,                  0);
    add(1, 0, 3'd2, 32'h87FF_FFFC, 64'h0,                  14, 64'h1_7FFF_FFFF,        2, 0, 64'h7FFF_FFFF,          1);
    add(1, 0, 3'd2, 32'h8800_0000, 64'h0,                  15, 64'h0,                  0, 1, 64'h0,                  0);
    add(1, 0, 3'd0, 32'h7FFF_FFFF, 64'h0,                  16, 64'h0,                  0, 1, 64'h0,                  0);
    add(0, 0, 3'd3, 32'h0000_0004, 64'hFFFF_0000_FFFF_0001, 31, 64'h0,                 0, 0, 64'hFFFF_0000_FFFF_0001, 0);
`ifdef LSU_MISALIGN_TRAP_EN
    add(1, 0, 3'd2, 32'h8000_0002, 64'h0,                  17, 64'h1234_5678,          2, 1, 64'h0,                  0);
`else
    add(1, 0, 3'd2, 32'h8000_0002, 64'h0,                  17, 64'h1234_5678,          2, 0, 64'h1234_5678,          1);
`endif

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_in_ready", 64'(bus.in_ready), 64'd1);
    chk("reset_out_valid", 64'(bus.out_valid), 64'd0);
    chk("reset_dc_inst_update", 64'(bus.dc_inst_update), 64'd0);
    chk("reset_out_data", bus.out_data, 64'd0);

    for (int i = 0; i < vecs.size(); i++) begin
      do_op(vecs[i].ld, vecs[i].st, vecs[i].f3, vecs[i].addr, vecs[i].wd, vecs[i].rd,
            vecs[i].rdat, vecs[i].dly, 0);
      check_op($sformatf("vec%0d", i), vecs[i].ld, vecs[i].st, vecs[i].addr, vecs[i].e_fault,
               vecs[i].e_data, vecs[i].rd, vecs[i].e_acc, vecs[i].dly, 0);
    end

    // Store size/alignment onto the cache write port.
    do_op(1'b0, 1'b1, 3'd1, 32'h8000_0010, 64'hAAAA_BBBB_CCCC_DDDD, 5'd3, 64'h0, 2, 0);
    chk("sh_wmask", 64'(g_wmask), 64'h03);
    chk("sh_wdata", g_wdata, 64'hDDDD);
    chk("sh_wen", 64'(g_wen), 64'd1);
    do_op(1'b0, 1'b1, 3'd2, 32'h8000_0020, 64'h1122_3344_5566_7788, 5'd3, 64'h0, 0, 0);
    chk("sw_wmask", 64'(g_wmask), 64'h0F);
    chk("sw_wdata", g_wdata, 64'h5566_7788);

    // Long miss: 20 request cycles, then writeback stalls for 3.
    do_op(1'b1, 1'b0, 3'd3, 32'h8000_0100, 64'h0, 5'd20, 64'h0123_4567_89AB_CDEF, 19, 3);
    check_op("slow", 1'b1, 1'b0, 32'h8000_0100, 1'b0, 64'h0123_4567_89AB_CDEF, 5'd20, 1'b1, 19, 3);

    // A finish pulse while idle must not produce a result.
    @(negedge clk);
    bus.dc_cache_finish = 1'b1;
    @(negedge clk);
    bus.dc_cache_finish = 1'b0;
    chk("stray_finish_valid", 64'(bus.out_valid), 64'd0);
    chk("stray_finish_ready", 64'(bus.in_ready), 64'd1);

    // Reset in the middle of an access.
    bus.in_valid = 1'b1; bus.in_load = 1'b1; bus.in_store = 1'b0; bus.in_funct3 = 3'd2;
    bus.in_addr = 32'h8000_0004; bus.in_rd = 5'd9;
    @(negedge clk);
    bus.in_valid = 1'b0; bus.in_load = 1'b0;
    chk("rst_mid_req_up", 64'(bus.dc_inst_update), 64'd1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_dc", {bus.dc_use_cache, bus.dc_r_ren, bus.dc_r_wen, bus.dc_inst_update,
                       bus.dc_wmask, bus.dc_raddr[23:0], bus.dc_waddr[23:0]}, 64'd0);
    chk("rst_mid_dc_addr", {bus.dc_raddr, bus.dc_waddr}, 64'd0);
    chk("rst_mid_dc_wdata", bus.dc_wdata, 64'd0);
    chk("rst_mid_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_mid_in_ready", 64'(bus.in_ready), 64'd1);
    rst = 1'b0;
    do_op(1'b0, 1'b0, 3'd0, 32'h0, 64'hCAFE, 5'd2, 64'h0, 0, 0);
    check_op("post_rst", 1'b0, 1'b0, 32'h0, 1'b0, 64'hCAFE, 5'd2, 1'b0, 0, 0);

    // Random ops against the reference model.
    for (int n = 0; n < 150; n++) begin
      logic        ld, st;
      logic [2:0]  f3;
      logic [31:0] a;
      logic [63:0] wd, rdat;
      logic [4:0]  rd;
      int          kind, sel, dly, stall;
      kind = $urandom_range(0, 9);
      ld = (kind == 1) || (kind >= 2 && kind <= 5);
      st = (kind == 1) || (kind >= 6);
      f3 = 3'($urandom_range(0, 7));
      sel = $urandom_range(0, 5);
      case (sel)
        0:       a = BASE + 32'($urandom_range(0, 255));
        1:       a = LIMIT - 32'd1 - 32'($urandom_range(0, 255));
        2:       a = LIMIT + 32'($urandom_range(0, 255));
        3:       a = BASE - 32'd1 - 32'($urandom_range(0, 255));
        4:       a = $urandom;
        default: a = BASE + 32'($urandom_range(0, 32'h07FF_FFFF));
      endcase
      wd = {$urandom, $urandom};
      rdat = {$urandom, $urandom};
      rd = 5'($urandom_range(0, 31));
      dly = $urandom_range(0, 4);
      stall = $urandom_range(0, 2);
      model(ld, st, f3, a, wd, rdat, m_fault, m_data, m_acc);
      do_op(ld, st, f3, a, wd, rd, rdat, dly, stall);
      check_op($sformatf("rnd%0d", n), ld, st, a, m_fault, m_data, rd, m_acc, dly, stall);
      if (m_acc && st && !g_timeout) begin
        int nb;
        logic [63:0] keep;
        nb = 1 << f3[1:0];
        keep = (nb == 8) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (8 * nb)) - 64'd1);
        chk($sformatf("rnd%0d_wmask", n), 64'(g_wmask), (64'd1 << nb) - 64'd1);
        chk($sformatf("rnd%0d_wdata", n), g_wdata, wd & keep);
      end
    end

    cyc = 0;
    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
